// File: rtl/md_sequencer.sv
// md_sequencer: iterative 32-bit signed multiply (radix-2 Booth) / divide (restoring) over one shared add/sub.
// Optional MD_EARLY_OUT_EN: zero-operand multiplies and divide-by-zero skip straight to DONE.
`default_nettype none

module md_sequencer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] p_hi;    // Booth P_hi, or partial remainder R when dividing
  logic [31:0] p_lo;    // Booth P_lo, or quotient Q when dividing
  logic        q_m1;
  logic [31:0] b_reg;   // B for multiply, |B| for divide
  logic        is_div, neg_q, div_zero, div_ovf;
  logic [31:0] res_q;
  logic        exc_q;

  logic        start, accept, early;
  logic [31:0] a_mag, b_mag, r_shift;
  logic [32:0] add_a, add_b, sum;
  logic        add_sub;

  assign start   = ctrl_MULT | ctrl_DIV;
  assign accept  = (state == IDLE) && start;
  assign a_mag   = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
  assign b_mag   = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;
  // R never reaches bit 31 between iterations, so the left shift loses nothing.
  assign r_shift = {p_hi[30:0], p_lo[31]};

`ifdef MD_EARLY_OUT_EN
  assign early = ctrl_MULT ? ((data_operandA == 32'd0) || (data_operandB == 32'd0))
                           : (data_operandB == 32'd0);
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = early ? DONE : ITER;
      ITER: if (cnt == 5'd31) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The single add/sub shared by every iteration and the quotient sign fix.
  always_comb begin
    add_a   = 33'd0;
    add_b   = 33'd0;
    add_sub = 1'b0;
    case (state)
      ITER: begin
        if (is_div) begin
          add_a   = {1'b0, r_shift};
          add_b   = {1'b0, b_reg};
          add_sub = 1'b1;
        end else begin
          add_a = {p_hi[31], p_hi};
          case ({p_lo[0], q_m1})
            2'b01: add_b = {b_reg[31], b_reg};
            2'b10: begin
              add_b   = {b_reg[31], b_reg};
              add_sub = 1'b1;
            end
            default: add_b = 33'd0;
          endcase
        end
      end
      FIX: begin
        if (is_div) begin
          add_b   = {1'b0, p_lo};
          add_sub = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign sum = add_sub ? (add_a - add_b) : (add_a + add_b);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= 5'd0;
      p_hi           <= 32'd0;
      p_lo           <= 32'd0;
      q_m1           <= 1'b0;
      b_reg          <= 32'd0;
      is_div         <= 1'b0;
      neg_q          <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      res_q          <= 32'd0;
      exc_q          <= 1'b0;
      data_result    <= 32'd0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      data_resultRDY <= (state == DONE);
      if (accept)
        busy <= 1'b1;
      else if (data_resultRDY)
        busy <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            cnt            <= 5'd0;
            q_m1           <= 1'b0;
            p_hi           <= 32'd0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            is_div         <= ~ctrl_MULT;
            neg_q          <= data_operandA[31] ^ data_operandB[31];
            div_zero       <= ~ctrl_MULT && (data_operandB == 32'd0);
            div_ovf        <= ~ctrl_MULT && (data_operandA == 32'h8000_0000)
                                         && (data_operandB == 32'hFFFF_FFFF);
            res_q          <= 32'd0;
            exc_q          <= ~ctrl_MULT && (data_operandB == 32'd0);
            if (ctrl_MULT) begin
              p_lo  <= data_operandA;
              b_reg <= data_operandB;
            end else begin
              p_lo  <= a_mag;
              b_reg <= b_mag;
            end
          end
        end
        ITER: begin
          cnt <= cnt + 5'd1;
          if (is_div) begin
            if (!sum[32]) begin
              p_hi <= sum[31:0];
              p_lo <= {p_lo[30:0], 1'b1};
            end else begin
              p_hi <= r_shift;
              p_lo <= {p_lo[30:0], 1'b0};
            end
          end else begin
            // Shift the 33-bit sum so the sign of P_hi survives an add overflow.
            p_hi <= sum[32:1];
            p_lo <= {sum[0], p_lo[31:1]};
            q_m1 <= p_lo[0];
          end
        end
        FIX: begin
          if (is_div) begin
            if (div_zero) begin
              res_q <= 32'd0;
              exc_q <= 1'b1;
            end else if (div_ovf) begin
              res_q <= 32'h8000_0000;
              exc_q <= 1'b1;
            end else begin
              res_q <= neg_q ? sum[31:0] : p_lo;
              exc_q <= 1'b0;
            end
          end else begin
            res_q <= p_lo;
            exc_q <= (p_hi != {32{p_lo[31]}});
          end
        end
        DONE: begin
          data_result    <= res_q;
          data_exception <= exc_q;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed vectors; stimulus pushes expectations, a monitor pops them on each ready pulse.
`default_nettype none

module tb_md_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = 32'd0;
  logic [31:0] data_operandB = 32'd0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  md_sequencer dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

`ifdef MD_EARLY_OUT_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 34;
`endif

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          lat;
    int          cap;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (data_resultRDY) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready at cycle %0d: got ready=1 expected 0", cyc);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_result"}, data_result, e.res);
          chk({e.name, "_exc"}, {31'd0, data_exception}, {31'd0, e.exc});
          chk({e.name, "_latency"}, cyc - e.cap, e.lat);
        end
      end
    end
  end

  task automatic issue(input string name, input logic m, input logic d,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ee, input int lat, input bit push);
    exp_t e;
    @(negedge clock);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #2;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    if (push) begin
      e.res = er; e.exc = ee; e.lat = lat; e.cap = cyc; e.name = name;
      sb.push_back(e);
      chk({name, "_busy_after_capture"}, {31'd0, busy}, 32'd1);
    end
  endtask

  task automatic wait_done(input bit chk_busy);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clock);
      #3;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no ready within %0d cycles, expected a ready pulse", n);
      sb.delete();
    end
    if (chk_busy) begin
      @(posedge clock);
      #3;
      chk("busy_after_ready", {31'd0, busy}, 32'd0);
      chk("ready_one_cycle", {31'd0, data_resultRDY}, 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #3;
    chk("reset_result", data_result, 32'd0);
    chk("reset_exc", {31'd0, data_exception}, 32'd0);
    chk("reset_ready", {31'd0, data_resultRDY}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    issue("mul_7_m3", 1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 34, 1);
    wait_done(1);
    issue("mul_ovf", 1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1, 34, 1);
    wait_done(0);
    issue("mul_min_1", 1, 0, 32'h8000_0000, 32'd1, 32'h8000_0000, 0, 34, 1);
    wait_done(0);
    // Next start lands on the edge that ends the ready cycle.
    issue("div_m7_2", 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 34, 1);
    wait_done(0);
    issue("div_100_m7", 0, 1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 0, 34, 1);
    wait_done(1);
    issue("div_by_zero", 0, 1, 32'd5, 32'd0, 32'd0, 1, ZLAT, 1);
    wait_done(1);
    issue("div_min_m1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 34, 1);
    wait_done(0);
    issue("mul_zero", 1, 0, 32'd0, 32'd5, 32'd0, 0, ZLAT, 1);
    wait_done(0);

    issue("mul_ignore_div", 1, 0, 32'd123, 32'hFFFF_FFD3, 32'hFFFF_EA61, 0, 34, 1);
    repeat (9) @(negedge clock);
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd50;
    data_operandB = 32'd5;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    wait_done(1);

    issue("mul_and_div", 1, 1, 32'd6, 32'd7, 32'd42, 0, 34, 1);
    wait_done(1);

    issue("aborted", 1, 0, 32'd9, 32'd9, 32'd0, 0, 0, 0);
    repeat (15) @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_result", data_result, 32'd0);
    chk("abort_exc", {31'd0, data_exception}, 32'd0);
    chk("abort_ready", {31'd0, data_resultRDY}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    chk("abort_still_idle", {31'd0, busy}, 32'd0);

    issue("mul_3_4", 1, 0, 32'd3, 32'd4, 32'd12, 0, 34, 1);
    wait_done(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
